// File: rtl/multi_sync_filter.sv
// Multi-bit synchronizer with per-channel persistence filter and edge pulses.
// Each channel is independent; the vector is not coherent across bits.
module multi_sync_filter #(
    parameter int unsigned      WIDTH      = 4,
    parameter int unsigned      STAGES     = 2,
    parameter int unsigned      FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int unsigned      CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("multi_sync_filter: STAGES must be >= 2");
        end
        if (FILTER_LEN < 1) begin : g_bad_filter_len
            $error("multi_sync_filter: FILTER_LEN must be >= 1");
        end
    endgenerate

    // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
    logic [STAGES-1:0][WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= {STAGES{RESET_VAL}};
        end else begin
            sync_reg[0] <= async_in;
            for (int s = 1; s < STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
        end
    end

    assign sync_out = sync_reg[STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             filt_reg;
            logic             filt_next;
            logic             rise_reg;
            logic             rise_next;
            logic             fall_reg;
            logic             fall_next;

            // Counter tracks how long sync_out has disagreed with the filtered level.
            always_comb begin
                cnt_next  = '0;
                filt_next = filt_reg;
                rise_next = 1'b0;
                fall_next = 1'b0;
                if (sync_out[gi] != filt_reg) begin
                    if (cnt_reg == CNT_MAX) begin
                        filt_next = sync_out[gi];
                        rise_next = sync_out[gi];
                        fall_next = ~sync_out[gi];
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg  <= '0;
                    filt_reg <= RESET_VAL[gi];
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    filt_reg <= filt_next;
                    rise_reg <= rise_next;
                    fall_reg <= fall_next;
                end
            end

            assign filt_out[gi]   = filt_reg;
            assign rise_pulse[gi] = rise_reg;
            assign fall_pulse[gi] = fall_reg;
        end
    endgenerate

    assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_multi_sync_filter.sv
// Directed bench for multi_sync_filter: default config (dut0) plus STAGES=3,
// FILTER_LEN=1, RESET_VAL=4'hA config (dut1).
module tb_multi_sync_filter;

    logic       clk = 1'b0;
    logic       rst_n0, rst_n1;
    logic [3:0] async_in0, async_in1;
    logic [3:0] sync0, filt0, rise0, fall0;
    logic [3:0] sync1, filt1, rise1, fall1;
    logic       any0, any1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_sync_filter #(
        .WIDTH(4), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(4'h0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n0), .async_in(async_in0),
        .sync_out(sync0), .filt_out(filt0), .rise_pulse(rise0),
        .fall_pulse(fall0), .any_change(any0)
    );

    multi_sync_filter #(
        .WIDTH(4), .STAGES(3), .FILTER_LEN(1), .RESET_VAL(4'hA)
    ) dut1 (
        .clk(clk), .rst_n(rst_n1), .async_in(async_in1),
        .sync_out(sync1), .filt_out(filt1), .rise_pulse(rise1),
        .fall_pulse(fall1), .any_change(any1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle0(input logic [3:0] val);
        async_in0 = val;
        repeat (12) tick();
    endtask

    task automatic show0(input string tag, input int e);
        $display("[%s] e=%0d in=%h sync=%h filt=%h rise=%h fall=%h any=%b",
                 tag, e, async_in0, sync0, filt0, rise0, fall0, any0);
    endtask

    task automatic test_reset();
        logic [3:0] es, ef, er;
        rst_n0    = 1'b0;
        async_in0 = 4'hF;
        for (int e = 1; e <= 3; e++) begin
            tick();
            show0("reset", e);
            checks++;
            if ({sync0, filt0, rise0, fall0, any0} !== 17'h0) begin
                failures++;
                $display("FAIL reset_outputs e=%0d got=%h exp=0", e, {sync0, filt0, rise0, fall0, any0});
            end
        end
        rst_n0 = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            show0("release", e);
            es = (e >= 2) ? 4'hF : 4'h0;
            ef = (e >= 6) ? 4'hF : 4'h0;
            er = (e == 6) ? 4'hF : 4'h0;
            checks++;
            if (sync0 !== es) begin
                failures++;
                $display("FAIL release_sync e=%0d got=%h exp=%h", e, sync0, es);
            end
            checks++;
            if (filt0 !== ef) begin
                failures++;
                $display("FAIL release_filt e=%0d got=%h exp=%h", e, filt0, ef);
            end
            checks++;
            if (rise0 !== er || fall0 !== 4'h0 || any0 !== (e == 6)) begin
                failures++;
                $display("FAIL release_pulse e=%0d got rise=%h fall=%h any=%b exp rise=%h fall=0 any=%b",
                         e, rise0, fall0, any0, er, (e == 6));
            end
        end
    endtask

    task automatic test_glitch();
        logic es;
        settle0(4'h0);
        checks++;
        if (filt0 !== 4'h0) begin
            failures++;
            $display("FAIL glitch_pre_filt got=%h exp=0", filt0);
        end
        async_in0 = 4'h1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 3) async_in0 = 4'h0;
            show0("glitch", e);
            es = (e >= 2 && e <= 4);
            checks++;
            if (sync0[0] !== es) begin
                failures++;
                $display("FAIL glitch_sync e=%0d got=%b exp=%b", e, sync0[0], es);
            end
            checks++;
            if (filt0 !== 4'h0 || rise0 !== 4'h0 || fall0 !== 4'h0 || any0 !== 1'b0) begin
                failures++;
                $display("FAIL glitch_filter e=%0d got filt=%h rise=%h fall=%h any=%b exp all 0",
                         e, filt0, rise0, fall0, any0);
            end
        end
        checks++;
        if (dut0.g_chan[0].cnt_reg !== 2'd0) begin
            failures++;
            $display("FAIL glitch_cnt got=%0d exp=0", dut0.g_chan[0].cnt_reg);
        end
    endtask

    task automatic test_min_accept();
        logic es, ef, er, ev;
        async_in0 = 4'h1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 4) async_in0 = 4'h0;
            show0("accept", e);
            es = (e >= 2 && e <= 5);
            ef = (e >= 6 && e <= 9);
            er = (e == 6);
            ev = (e == 10);
            checks++;
            if (sync0[0] !== es) begin
                failures++;
                $display("FAIL accept_sync e=%0d got=%b exp=%b", e, sync0[0], es);
            end
            checks++;
            if (filt0[0] !== ef) begin
                failures++;
                $display("FAIL accept_filt e=%0d got=%b exp=%b", e, filt0[0], ef);
            end
            checks++;
            if (rise0[0] !== er || fall0[0] !== ev || any0 !== (er | ev)) begin
                failures++;
                $display("FAIL accept_pulse e=%0d got rise=%b fall=%b any=%b exp rise=%b fall=%b any=%b",
                         e, rise0[0], fall0[0], any0, er, ev, er | ev);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] ef, er, ev;
        settle0(4'b0011);
        checks++;
        if (filt0 !== 4'b0011) begin
            failures++;
            $display("FAIL simul_pre_filt got=%h exp=3", filt0);
        end
        async_in0 = 4'b1100;
        for (int e = 1; e <= 7; e++) begin
            tick();
            show0("simul", e);
            ef = (e >= 6) ? 4'b1100 : 4'b0011;
            er = (e == 6) ? 4'b1100 : 4'b0000;
            ev = (e == 6) ? 4'b0011 : 4'b0000;
            checks++;
            if (filt0 !== ef) begin
                failures++;
                $display("FAIL simul_filt e=%0d got=%h exp=%h", e, filt0, ef);
            end
            checks++;
            if (rise0 !== er || fall0 !== ev || any0 !== (e == 6)) begin
                failures++;
                $display("FAIL simul_pulse e=%0d got rise=%h fall=%h any=%b exp rise=%h fall=%h any=%b",
                         e, rise0, fall0, any0, er, ev, (e == 6));
            end
        end
    endtask

    task automatic test_reset_mid_filter();
        logic [3:0] ef, er;
        async_in0 = 4'b1000;
        for (int e = 1; e <= 4; e++) begin
            tick();
            show0("midrst", e);
            checks++;
            if (filt0 !== 4'b1100 || any0 !== 1'b0) begin
                failures++;
                $display("FAIL midrst_hold e=%0d got filt=%h any=%b exp filt=c any=0", e, filt0, any0);
            end
        end
        checks++;
        if (dut0.g_chan[2].cnt_reg !== 2'd2) begin
            failures++;
            $display("FAIL midrst_cnt2 got=%0d exp=2", dut0.g_chan[2].cnt_reg);
        end
        rst_n0 = 1'b0;
        tick();
        show0("midrst", 5);
        checks++;
        if (filt0 !== 4'h0 || sync0 !== 4'h0 || rise0 !== 4'h0 || fall0 !== 4'h0 || any0 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_reset got sync=%h filt=%h rise=%h fall=%h any=%b exp all 0",
                     sync0, filt0, rise0, fall0, any0);
        end
        rst_n0 = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            show0("midrel", e);
            ef = (e >= 6) ? 4'b1000 : 4'b0000;
            er = (e == 6) ? 4'b1000 : 4'b0000;
            checks++;
            if (filt0 !== ef) begin
                failures++;
                $display("FAIL midrel_filt e=%0d got=%h exp=%h", e, filt0, ef);
            end
            checks++;
            if (rise0 !== er || fall0 !== 4'h0) begin
                failures++;
                $display("FAIL midrel_pulse e=%0d got rise=%h fall=%h exp rise=%h fall=0", e, rise0, fall0, er);
            end
        end
    endtask

    task automatic test_alt_config();
        logic [3:0] es, ef, er, ev;
        async_in1 = 4'h5;
        rst_n1    = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            tick();
            $display("[alt_rst] e=%0d sync=%h filt=%h rise=%h fall=%h any=%b", e, sync1, filt1, rise1, fall1, any1);
            checks++;
            if (sync1 !== 4'hA || filt1 !== 4'hA || rise1 !== 4'h0 || fall1 !== 4'h0 || any1 !== 1'b0) begin
                failures++;
                $display("FAIL alt_reset e=%0d got sync=%h filt=%h rise=%h fall=%h any=%b exp a a 0 0 0",
                         e, sync1, filt1, rise1, fall1, any1);
            end
        end
        rst_n1 = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            $display("[alt] e=%0d sync=%h filt=%h rise=%h fall=%h any=%b", e, sync1, filt1, rise1, fall1, any1);
            es = (e >= 3) ? 4'h5 : 4'hA;
            ef = (e >= 4) ? 4'h5 : 4'hA;
            er = (e == 4) ? 4'h5 : 4'h0;
            ev = (e == 4) ? 4'hA : 4'h0;
            checks++;
            if (sync1 !== es) begin
                failures++;
                $display("FAIL alt_sync e=%0d got=%h exp=%h", e, sync1, es);
            end
            checks++;
            if (filt1 !== ef) begin
                failures++;
                $display("FAIL alt_filt e=%0d got=%h exp=%h", e, filt1, ef);
            end
            checks++;
            if (rise1 !== er || fall1 !== ev || any1 !== (e == 4)) begin
                failures++;
                $display("FAIL alt_pulse e=%0d got rise=%h fall=%h any=%b exp rise=%h fall=%h any=%b",
                         e, rise1, fall1, any1, er, ev, (e == 4));
            end
        end
    endtask

    initial begin
        rst_n0    = 1'b0;
        rst_n1    = 1'b0;
        async_in0 = 4'hF;
        async_in1 = 4'h5;
        test_reset();
        test_glitch();
        test_min_accept();
        test_simultaneous();
        test_reset_mid_filter();
        test_alt_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
